// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU-sharing controller.
// Op codes above OP_MAX are rejected with an error response.
package alu_pkg;

    localparam int OP_MAX = 5;

    typedef enum logic [2:0] {
        OP_SUM = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (int'(op) <= OP_MAX);
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
module alu_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    // Combinational grant decode
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case ({valid1, valid0})
            2'b01: grant0 = 1'b1;
            2'b10: grant1 = 1'b1;
            2'b11: begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 8-bit ALU between two valid/ready requesters,
// one operation in flight: IDLE accepts, EXEC samples the ALU, RESP hands back.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [7:0]       rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [7:0]       rsp1_data,
    output logic             rsp1_err,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_r,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    ctrl_state_t      state_r;
    ctrl_state_t      next_state_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             req_hs_s;
    logic             rsp_hs_s;
    logic             last_grant_r;
    logic             owner_r;
    logic [2:0]       op_r;
    logic [7:0]       a_r;
    logic [7:0]       b_r;
    logic [7:0]       result_r;
    logic             err_r;
    logic [CNT_W-1:0] ops_done_r;

    alu_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant0     (grant0_s),
        .grant1     (grant1_s)
    );

    // A grant in IDLE is itself the handshake, since ready follows the grant there.
    assign req_hs_s = (state_r == IDLE) && (grant0_s || grant1_s);
    assign rsp_hs_s = (state_r == RESP) && (owner_r ? rsp1_ready : rsp0_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_hs_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: next_state_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from state and owner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (state_r)
            IDLE: begin
                req0_ready = grant0_s;
                req1_ready = grant1_s;
            end
            EXEC: busy = 1'b1;
            RESP: begin
                busy       = 1'b1;
                rsp0_valid = ~owner_r;
                rsp1_valid = owner_r;
            end
            default: busy = 1'b1;
        endcase
    end

    // Command latch, result capture and arbitration history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r      <= 1'b0;
            op_r         <= 3'd0;
            a_r          <= 8'd0;
            b_r          <= 8'd0;
            result_r     <= 8'd0;
            err_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            if (req_hs_s) begin
                owner_r <= grant1_s;
                op_r    <= grant1_s ? req1_op : req0_op;
                a_r     <= grant1_s ? req1_a  : req0_a;
                b_r     <= grant1_s ? req1_b  : req0_b;
            end
            // Illegal op codes never look at alu_r, whatever the ALU drives.
            if (state_r == EXEC) begin
                if (op_legal(op_r)) begin
                    result_r <= alu_r;
                    err_r    <= 1'b0;
                end else begin
                    result_r <= 8'd0;
                    err_r    <= 1'b1;
                end
            end
            if (rsp_hs_s) begin
                last_grant_r <= owner_r;
            end
        end
    end

    // Saturating count of completed responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done_r <= {CNT_W{1'b0}};
        end else if (rsp_hs_s && (ops_done_r != {CNT_W{1'b1}})) begin
            ops_done_r <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign rsp0_data = result_r;
    assign rsp1_data = result_r;
    assign rsp0_err  = err_r;
    assign rsp1_err  = err_r;
    assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios then randomized traffic
// compared against a transaction-level reference model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0]  rsp0_data, rsp1_data;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_r;
    logic        busy;
    logic [15:0] ops_done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ops  = 0;
    logic m_last   = 1'b1;

    alu_share_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // External ALU; drives junk for illegal codes so the controller must ignore it
    always_comb begin
        case (alu_op)
            3'd0:    alu_r = alu_a + alu_b;
            3'd1:    alu_r = alu_a - alu_b;
            3'd2:    alu_r = alu_a & alu_b;
            3'd3:    alu_r = alu_a | alu_b;
            3'd4:    alu_r = {alu_a[6:0], 1'b0};
            3'd5:    alu_r = {1'b0, alu_a[7:1]};
            default: alu_r = 8'hA5;
        endcase
    end

    // Returns {err, data} straight from the op-code table
    function automatic logic [8:0] ref_result(input int op, input int a, input int b);
        int d;
        case (op)
            0:       d = (a + b) % 256;
            1:       d = (a - b + 256) % 256;
            2:       d = a & b;
            3:       d = a | b;
            4:       d = (a * 2) % 256;
            5:       d = a / 2;
            default: return 9'h100;
        endcase
        return {1'b0, 8'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; the losing requester is held valid while busy to prove it is not accepted
    task automatic txn(input logic v0, input logic v1,
                       input int op0, input int a0, input int b0,
                       input int op1, input int a1, input int b1,
                       input int hold);
        int win, wop, wa, wb;
        logic [8:0] e;
        check("idle_before", busy, 0);
        if (v0 && v1) win = m_last ? 0 : 1;
        else if (v0)  win = 0;
        else          win = 1;
        wop = win ? op1 : op0;
        wa  = win ? a1 : a0;
        wb  = win ? b1 : b0;
        e   = ref_result(wop, wa, wb);
        req0_op = 3'(op0); req0_a = 8'(a0); req0_b = 8'(b0);
        req1_op = 3'(op1); req1_a = 8'(a1); req1_b = 8'(b1);
        req0_valid = v0; req1_valid = v1;
        #1;
        check("req0_ready", req0_ready, win == 0);
        check("req1_ready", req1_ready, win == 1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("exec_busy", busy, 1);
        check("exec_rdy", {req1_ready, req0_ready}, 0);
        check("exec_rspv", {rsp1_valid, rsp0_valid}, 0);
        check("alu_op", alu_op, wop);
        check("alu_a", alu_a, wa);
        check("alu_b", alu_b, wb);
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            if (win == 0) begin
                rsp0_ready = 1'b0; rsp1_ready = 1'b1;
            end else begin
                rsp0_ready = 1'b1; rsp1_ready = 1'b0;
            end
            #1;
            check("rsp_valid", {rsp1_valid, rsp0_valid}, win ? 2 : 1);
            check("rsp_data", win ? rsp1_data : rsp0_data, e[7:0]);
            check("rsp_err", win ? rsp1_err : rsp0_err, e[8]);
            check("resp_rdy", {req1_ready, req0_ready}, 0);
            check("resp_alu_a", alu_a, wa);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp0_ready = (win == 0); rsp1_ready = (win == 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        m_last = win[0];
        if (exp_ops < 65535) exp_ops++;
        check("ops_done", ops_done, exp_ops);
        check("done_busy", busy, 0);
        check("done_rspv", {rsp1_valid, rsp0_valid}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int pat;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 3'd0; req0_a = 8'd0; req0_b = 8'd0;
        req1_op = 3'd0; req1_a = 8'd0; req1_b = 8'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ops", ops_done, 0);
        check("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        check("rst_data", {rsp1_data, rsp0_data}, 0);
        check("rst_err", {rsp1_err, rsp0_err}, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: add overflow, tie arbitration and alternation
        txn(1, 0, 0, 8'h7F, 8'h01, 0, 0, 0, 0);
        txn(1, 1, 1, 8'h00, 8'h01, 2, 8'hF0, 8'h3C, 0);
        txn(1, 1, 1, 8'h00, 8'h01, 2, 8'hF0, 8'h3C, 0);
        txn(1, 1, 3, 8'h0F, 8'h50, 1, 8'h10, 8'h20, 1);
        // Backpressure on the response, then illegal and shift-right ops
        txn(0, 1, 0, 8'h11, 8'h22, 4, 8'h81, 8'h00, 5);
        txn(1, 0, 6, 8'h12, 8'h34, 0, 0, 0, 0);
        txn(1, 0, 5, 8'h81, 8'h00, 0, 0, 0, 0);

        // Reset during RESP aborts the operation
        req0_op = 3'd0; req0_a = 8'h03; req0_b = 8'h04; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_rspv", rsp0_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_rspv", {rsp1_valid, rsp0_valid}, 0);
        check("arst_busy", busy, 0);
        check("arst_ops", ops_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1;
        exp_ops = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
            check("post_rst_busy", busy, 0);
        end
        txn(1, 1, 0, 8'hC8, 8'h64, 1, 8'h05, 8'h09, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            pat = $urandom_range(1, 3);
            txn((pat & 1) != 0, (pat & 2) != 0,
                $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
